// File: rtl/rr_pkg.sv
// Shared defaults and derived widths for the round-robin requester and arbiter benches.
package rr_pkg;
   localparam int RR_CLIENTS  = 32;
   localparam int RR_DEPTH    = 4;
   localparam int RR_MAX_WAIT = 31;
   // Pending counter holds 0..DEPTH, wait counter holds 0..MAX_WAIT+1.
   localparam int RR_CNT_W    = $clog2(RR_DEPTH + 1);
   localparam int RR_WT_W     = $clog2(RR_MAX_WAIT + 2);
endpackage

// File: rtl/rr_client_slot.sv
// One client's pending-job counter, grant-wait counter and status decode.
module rr_client_slot
   import rr_pkg::*;
#(
   parameter int DEPTH    = RR_DEPTH,
   parameter int MAX_WAIT = RR_MAX_WAIT
) (
   input  logic clock,
   input  logic reset,
   input  logic push,
   input  logic grant,
   output logic request,
   output logic full,
   output logic starve,
   output logic drop,
   output logic bad_grant
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int WT_W  = $clog2(MAX_WAIT + 2);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
   localparam logic [WT_W-1:0]  WT_MAX  = WT_W'(MAX_WAIT + 1);

   logic [CNT_W-1:0] cnt;
   logic [WT_W-1:0]  wt;
   logic             take;
   logic             accept;

   // Status is decoded from registered state only.
   assign request   = (cnt != '0);
   assign full      = (cnt == CNT_MAX);
   assign starve    = (wt == WT_MAX);
   // A grant only counts when there is something to serve.
   assign take      = grant & request;
   assign bad_grant = grant & ~request;
   // A full slot still takes a push if a job leaves in the same cycle.
   assign accept    = push & (~full | take);
   assign drop      = push & full & ~take;

   // Pending counter: +1 on accepted push, -1 on served grant, both cancel.
   always_ff @(posedge clock) begin
      if (reset)
         cnt <= '0;
      else if (accept && !take)
         cnt <= cnt + CNT_W'(1);
      else if (take && !accept)
         cnt <= cnt - CNT_W'(1);
   end

   // Wait counter: saturating count of ungranted request cycles.
   always_ff @(posedge clock) begin
      if (reset || !request || grant)
         wt <= '0;
      else if (wt != WT_MAX)
         wt <= wt + WT_W'(1);
   end
endmodule

// File: rtl/rr_requester.sv
// Per-client request tracking in front of a round-robin arbiter, with sticky error flags.
module rr_requester
   import rr_pkg::*;
#(
   parameter int CLIENTS  = RR_CLIENTS,
   parameter int DEPTH    = RR_DEPTH,
   parameter int MAX_WAIT = RR_MAX_WAIT
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [CLIENTS-1:0] push,
   input  logic [CLIENTS-1:0] grant,
   output logic [CLIENTS-1:0] request,
   output logic [CLIENTS-1:0] full,
   output logic [CLIENTS-1:0] starve,
   output logic               proto_err,
   output logic               overflow
);
   logic [CLIENTS-1:0] drop;
   logic [CLIENTS-1:0] bad_grant;
   logic               multi_grant;

   genvar i;
   generate
      for (i = 0; i < CLIENTS; i++) begin : g_slot
         rr_client_slot #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) u_slot (
            .clock     (clock),
            .reset     (reset),
            .push      (push[i]),
            .grant     (grant[i]),
            .request   (request[i]),
            .full      (full[i]),
            .starve    (starve[i]),
            .drop      (drop[i]),
            .bad_grant (bad_grant[i])
         );
      end
   endgenerate

   // Clearing the lowest set bit leaves something only if two or more bits were set.
   assign multi_grant = ((grant & (grant - CLIENTS'(1))) != '0);

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         proto_err <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         proto_err <= proto_err | (|bad_grant) | multi_grant;
         overflow  <= overflow | (|drop);
      end
   end
endmodule

// File: tb/tb_rr_requester.sv
// Randomized and directed checks of rr_requester against a cycle-level reference model.
module tb_rr_requester;
   localparam int N  = 32;
   localparam int D  = 4;
   localparam int MW = 31;

   logic         clock = 1'b0;
   logic         reset;
   logic [N-1:0] push, grant;
   logic [N-1:0] request, full, starve;
   logic         proto_err, overflow;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference state: job counts and wait lengths as plain integers.
   int m_jobs [N];
   int m_wait [N];
   bit m_perr, m_ovf;
   int rr_ptr = 0;

   rr_requester dut (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .grant     (grant),
      .request   (request),
      .full      (full),
      .starve    (starve),
      .proto_err (proto_err),
      .overflow  (overflow)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // Advance the model by one clock using the inputs applied in that cycle.
   task automatic model_step(input logic [N-1:0] p, input logic [N-1:0] g, input logic r);
      int ng;
      if (r) begin
         foreach (m_jobs[k]) begin m_jobs[k] = 0; m_wait[k] = 0; end
         m_perr = 0; m_ovf = 0;
         return;
      end
      ng = 0;
      for (int k = 0; k < N; k++) ng += g[k];
      if (ng > 1) m_perr = 1;
      for (int k = 0; k < N; k++) begin
         bit waiting, served;
         waiting = (m_jobs[k] > 0);
         served  = g[k] && waiting;
         if (g[k] && !waiting) m_perr = 1;
         if (p[k] && m_jobs[k] == D && !served) m_ovf = 1;
         else m_jobs[k] = m_jobs[k] + int'(p[k]) - int'(served);
         if (!waiting || g[k]) m_wait[k] = 0;
         else if (m_wait[k] <= MW) m_wait[k]++;
      end
   endtask

   task automatic compare_all();
      logic [N-1:0] er, ef, es;
      for (int k = 0; k < N; k++) begin
         er[k] = (m_jobs[k] > 0);
         ef[k] = (m_jobs[k] == D);
         es[k] = (m_wait[k] > MW);
      end
      chk("request", 64'(request), 64'(er));
      chk("full", 64'(full), 64'(ef));
      chk("starve", 64'(starve), 64'(es));
      chk("proto_err", 64'(proto_err), 64'(m_perr));
      chk("overflow", 64'(overflow), 64'(m_ovf));
   endtask

   // Apply inputs away from the edge, clock once, update model, compare just after.
   task automatic step(input logic [N-1:0] p, input logic [N-1:0] g, input logic r);
      push = p; grant = g; reset = r;
      @(posedge clock);
      model_step(p, g, r);
      #1;
      compare_all();
   endtask

   function automatic logic [N-1:0] bit1(input int k);
      logic [N-1:0] v;
      v = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   // Simple round-robin arbiter standing in for rr_arbiter.
   function automatic logic [N-1:0] rr_pick(input logic [N-1:0] req);
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (rr_ptr + k) % N;
         if (req[idx]) begin
            rr_ptr = (idx + 1) % N;
            return bit1(idx);
         end
      end
      return '0;
   endfunction

   initial begin
      logic [N-1:0] g;
      push = '0; grant = '0; reset = 1'b1;
      #2;

      // Reset state, with push/grant ignored during reset.
      step('1, '1, 1'b1);
      chk("rst_request", 64'(request), 64'd0);
      chk("rst_perr", 64'(proto_err), 64'd0);

      // Single job: request up for two cycles, dropped after grant.
      step(bit1(4), '0, 1'b0);
      chk("c4_req_t2", 64'(request[4]), 64'd1);
      step('0, '0, 1'b0);
      chk("c4_req_t3", 64'(request[4]), 64'd1);
      step('0, bit1(4), 1'b0);
      chk("c4_req_t4", 64'(request[4]), 64'd0);
      chk("c4_starve", 64'(starve[4]), 64'd0);

      // Fill client 7 and overflow it.
      for (int k = 1; k <= 5; k++) begin
         step(bit1(7), '0, 1'b0);
         if (k == 4) begin
            chk("c7_full4", 64'(full[7]), 64'd1);
            chk("c7_ovf4", 64'(overflow), 64'd0);
         end
      end
      chk("c7_ovf5", 64'(overflow), 64'd1);
      chk("c7_full5", 64'(full[7]), 64'd1);
      for (int k = 1; k <= 4; k++) begin
         step('0, bit1(7), 1'b0);
         chk("c7_drain", 64'(request[7]), 64'(k < 4));
      end

      // Full client with push+grant: accepted, no overflow.
      step('0, '0, 1'b1);
      for (int k = 0; k < 4; k++) step(bit1(3), '0, 1'b0);
      step(bit1(3), bit1(3), 1'b0);
      chk("c3_full_pg", 64'(full[3]), 64'd1);
      chk("c3_no_ovf", 64'(overflow), 64'd0);

      // Starvation under a stalled arbiter.
      step('0, '0, 1'b1);
      step(bit1(2), '0, 1'b0);
      for (int k = 1; k <= 40; k++) begin
         step('0, '0, 1'b0);
         if (k == 31) chk("c2_starve_31", 64'(starve[2]), 64'd0);
         if (k == 32) chk("c2_starve_32", 64'(starve[2]), 64'd1);
      end
      chk("c2_starve_40", 64'(starve[2]), 64'd1);
      step('0, bit1(2), 1'b0);
      chk("c2_starve_clr", 64'(starve[2]), 64'd0);
      chk("c2_req_clr", 64'(request[2]), 64'd0);

      // Grant without request: sticky protocol error, no underflow.
      step('0, bit1(9), 1'b0);
      chk("c9_perr", 64'(proto_err), 64'd1);
      chk("c9_req", 64'(request[9]), 64'd0);
      step(bit1(9), '0, 1'b0);
      step('0, bit1(9), 1'b0);
      chk("c9_no_uflow", 64'(request[9]), 64'd0);
      chk("c9_perr_sticky", 64'(proto_err), 64'd1);

      // Push and grant together keep the count.
      step('0, '0, 1'b1);
      chk("perr_rst", 64'(proto_err), 64'd0);
      step(bit1(0), '0, 1'b0);
      step(bit1(0), '0, 1'b0);
      step(bit1(0), bit1(0), 1'b0);
      chk("c0_pg", 64'(request[0]), 64'd1);
      step('0, bit1(0), 1'b0);
      chk("c0_one_left", 64'(request[0]), 64'd1);
      step('0, bit1(0), 1'b0);
      chk("c0_empty", 64'(request[0]), 64'd0);

      // Two grants in one cycle: error, both still served.
      step(bit1(1) | bit1(5), '0, 1'b0);
      step('0, bit1(1) | bit1(5), 1'b0);
      chk("multi_perr", 64'(proto_err), 64'd1);
      chk("multi_req", 64'(request[1] | request[5]), 64'd0);

      // Randomized traffic with occasional illegal grants and resets.
      for (int c = 0; c < 2000; c++) begin
         int m;
         logic [N-1:0] p;
         p = $urandom & $urandom;
         m = $urandom_range(0, 9);
         g = '0;
         if (m <= 6) begin
            int s;
            s = $urandom_range(0, N - 1);
            for (int k = 0; k < N; k++)
               if (g == '0 && request[(s + k) % N]) g = bit1((s + k) % N);
         end else if (m == 8) g = bit1($urandom_range(0, N - 1));
         else if (m == 9) g = bit1($urandom_range(0, N - 1)) | bit1($urandom_range(0, N - 1));
         step(p, g, (c % 250) == 0);
      end

      // Every client pushing continuously behind a round-robin arbiter.
      step('0, '0, 1'b1);
      for (int c = 0; c < 400; c++) begin
         push = '1; grant = '0; reset = 1'b0;
         g = rr_pick(request);
         step('1, g, 1'b0);
         chk("rr_no_starve", 64'(starve), 64'd0);
      end
      chk("rr_perr", 64'(proto_err), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
